sabr_mul_share_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer that time-shares one unsigned 71x4 -> 75-bit

---
 rtl/sabr_mul_share_arbiter.sv | 129 ++++++++++++
 tb/tb_sabr_mul_share_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sabr_mul_share_arbiter.sv
// Round-robin arbiter that time-shares one unsigned A x B multiplier among N_REQ
// burst requesters; the grant is held for a whole burst, results leave on a registered channel.
module sabr_mul_share_arbiter #(
  parameter int N_REQ   = 4,
  parameter int A_WIDTH = 71,
  parameter int B_WIDTH = 4,
  parameter int P_WIDTH = 75,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_last,
  input  logic [N_REQ*A_WIDTH-1:0]   req_a,
  input  logic [N_REQ*B_WIDTH-1:0]   req_b,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       out_valid,
  output logic [P_WIDTH-1:0]         out_prod,
  output logic [ID_W-1:0]            out_id,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic                       busy
);

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     w_rr_ptr_nxt;
  logic [ID_W-1:0]     r_grant;
  logic [ID_W-1:0]     w_grant_nxt;
  logic [ID_W-1:0]     w_pick;
  logic                w_found;
  logic                w_out_free;
  logic                w_accept;
  logic [ID_W-1:0]     w_grant_inc;
  logic [A_WIDTH-1:0]  w_a_sel;
  logic [B_WIDTH-1:0]  w_b_sel;
  logic [P_WIDTH-1:0]  w_prod;

  logic                r_out_valid;
  logic [P_WIDTH-1:0]  r_out_prod;
  logic [ID_W-1:0]     r_out_id;
  logic                r_out_last;

  // Descending scan so the smallest offset from rr_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_rr_ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(r_rr_ptr) + k) % N_REQ;
      if (req_valid[idx]) begin
        w_found = 1'b1;
        w_pick  = ID_W'(idx);
      end
    end
  end

  assign w_out_free  = !r_out_valid || out_ready;
  assign w_accept    = (r_state == HOLD) && req_valid[r_grant] && w_out_free;
  assign w_grant_inc = (r_grant == ID_W'(N_REQ - 1)) ? '0 : r_grant + 1'b1;
  assign w_a_sel     = req_a[r_grant*A_WIDTH +: A_WIDTH];
  assign w_b_sel     = req_b[r_grant*B_WIDTH +: B_WIDTH];
  assign w_prod      = P_WIDTH'(w_a_sel) * P_WIDTH'(w_b_sel);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state  <= ARB;
      r_rr_ptr <= '0;
      r_grant  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_grant  <= w_grant_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    w_grant_nxt  = r_grant;
    req_ready    = '0;
    case (r_state)
      ARB: begin
        if (w_found) begin
          w_grant_nxt = w_pick;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        req_ready[r_grant] = w_out_free;
        if (w_accept && req_last[r_grant]) begin
          w_rr_ptr_nxt = w_grant_inc;
          w_state_nxt  = ARB;
        end
      end
      default: w_state_nxt = ARB;
    endcase
  end

  // Accept and drain may coincide, giving one beat per cycle inside a burst.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_out_valid <= 1'b0;
      r_out_prod  <= '0;
      r_out_id    <= '0;
      r_out_last  <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_prod  <= w_prod;
      r_out_id    <= r_grant;
      r_out_last  <= req_last[r_grant];
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_prod  = r_out_prod;
  assign out_id    = r_out_id;
  assign out_last  = r_out_last;
  assign busy      = (r_state == HOLD) || r_out_valid;

endmodule

// File: tb/tb_sabr_mul_share_arbiter.sv
// Directed bench for sabr_mul_share_arbiter: per-requester beat sources plus a result log,
// with hand-computed expectations per scenario.
module tb_sabr_mul_share_arbiter;
  localparam int N = 4;
  localparam int AW = 71;
  localparam int BW = 4;
  localparam int PW = 75;

  logic            ap_clk = 1'b0;
  logic            ap_rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_last = '0;
  logic [N*AW-1:0] req_a = '0;
  logic [N*BW-1:0] req_b = '0;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [PW-1:0]   out_prod;
  logic [1:0]      out_id;
  logic            out_last;
  logic            out_ready = 1'b1;
  logic            busy;

  int checks = 0;
  int failures = 0;

  logic [AW-1:0] sa [N][16];
  logic [BW-1:0] sb [N][16];
  logic          sl [N][16];
  int            shead [N];
  int            scnt [N];

  logic [PW-1:0] col_prod [64];
  logic [1:0]    col_id [64];
  logic          col_last [64];
  int            col_n;

  sabr_mul_share_arbiter #(.N_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .req_valid(req_valid), .req_last(req_last),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .out_valid(out_valid),
    .out_prod(out_prod), .out_id(out_id), .out_last(out_last), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic clear_srcs();
    for (int i = 0; i < N; i++) begin
      shead[i] = 0;
      scnt[i]  = 0;
    end
    col_n = 0;
  endtask

  task automatic load(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b, input logic l);
    sa[i][scnt[i]] = a;
    sb[i][scnt[i]] = b;
    sl[i][scnt[i]] = l;
    scnt[i]++;
  endtask

  task automatic drive_srcs();
    for (int i = 0; i < N; i++) begin
      if (shead[i] < scnt[i]) begin
        req_valid[i]       = 1'b1;
        req_a[i*AW +: AW]  = sa[i][shead[i]];
        req_b[i*BW +: BW]  = sb[i][shead[i]];
        req_last[i]        = sl[i][shead[i]];
      end else begin
        req_valid[i]       = 1'b0;
        req_a[i*AW +: AW]  = '0;
        req_b[i*BW +: BW]  = '0;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  // Called with inputs settled mid-cycle; returns settled in the following cycle.
  task automatic step(input logic next_rdy);
    logic [N-1:0] acc;
    acc = req_valid & req_ready;
    if (out_valid && out_ready && col_n < 64) begin
      col_prod[col_n] = out_prod;
      col_id[col_n]   = out_id;
      col_last[col_n] = out_last;
      col_n++;
    end
    @(negedge ap_clk);
    for (int i = 0; i < N; i++) if (acc[i]) shead[i]++;
    drive_srcs();
    out_ready = next_rdy;
    #1;
  endtask

  task automatic do_reset();
    @(negedge ap_clk);
    ap_rst = 1'b1;
    clear_srcs();
    drive_srcs();
    out_ready = 1'b1;
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({out_valid, out_prod, out_id, out_last, req_ready, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b prod=%h id=%0d last=%b ready=%b busy=%b, want all 0",
               out_valid, out_prod, out_id, out_last, req_ready, busy);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    load(0, 71'd5, 4'd3, 1'b1);
    drive_srcs();
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin failures++; $display("FAIL single_arb_bubble: ready=%b want 0000", req_ready); end
    step(1'b1);
    checks++;
    if (req_ready !== 4'b0001 || busy !== 1'b1) begin
      failures++; $display("FAIL single_hold_ready: ready=%b busy=%b want 0001/1", req_ready, busy);
    end
    step(1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_prod !== 75'd15 || out_id !== 2'd0 || out_last !== 1'b1) begin
      failures++;
      $display("FAIL single_result: valid=%b prod=%0d id=%0d last=%b want 1/15/0/1", out_valid, out_prod, out_id, out_last);
    end
    checks++;
    if (req_ready !== 4'b0000) begin failures++; $display("FAIL single_release: ready=%b want 0000", req_ready); end
    step(1'b1);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL single_drain: valid=%b busy=%b want 0/0", out_valid, busy);
    end
  endtask

  task automatic test_wide();
    logic [AW-1:0] a_max;
    logic [PW-1:0] exp_p;
    a_max = '1;
    exp_p = {4'b1110, {67{1'b1}}, 4'b0001};
    do_reset();
    load(0, a_max, 4'd15, 1'b1);
    drive_srcs();
    #1;
    for (int c = 0; c < 6; c++) step(1'b1);
    checks++;
    if (col_n !== 1 || col_prod[0] !== exp_p) begin
      failures++; $display("FAIL wide_product: n=%0d prod=%h want 1/%h", col_n, col_prod[0], exp_p);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]    exp_id [6];
    logic [PW-1:0] exp_p [6];
    exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    exp_p  = '{75'd3, 75'd51, 75'd99, 75'd147, 75'd6, 75'd54};
    do_reset();
    for (int i = 0; i < N; i++) load(i, AW'(16*i + 1), 4'd3, 1'b1);
    load(0, 71'd2, 4'd3, 1'b1);
    load(1, 71'd18, 4'd3, 1'b1);
    drive_srcs();
    #1;
    for (int c = 0; c < 20; c++) step(1'b1);
    checks++;
    if (col_n !== 6) begin failures++; $display("FAIL rr_count: got %0d results want 6", col_n); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (col_id[k] !== exp_id[k] || col_prod[k] !== exp_p[k] || col_last[k] !== 1'b1) begin
        failures++;
        $display("FAIL rr_seq[%0d]: id=%0d prod=%0d last=%b want %0d/%0d/1", k, col_id[k], col_prod[k], col_last[k], exp_id[k], exp_p[k]);
      end
    end
  endtask

  task automatic test_burst_hold();
    logic [1:0]    exp_id [4];
    logic [PW-1:0] exp_p [4];
    logic          exp_l [4];
    exp_id = '{2'd1, 2'd1, 2'd1, 2'd2};
    exp_p  = '{75'd14, 75'd16, 75'd18, 75'd100};
    exp_l  = '{1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    load(1, 71'd7, 4'd2, 1'b0);
    load(1, 71'd8, 4'd2, 1'b0);
    load(1, 71'd9, 4'd2, 1'b1);
    load(2, 71'd100, 4'd1, 1'b1);
    drive_srcs();
    #1;
    for (int c = 0; c < 15; c++) step(1'b1);
    checks++;
    if (col_n !== 4) begin failures++; $display("FAIL burst_count: got %0d results want 4", col_n); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (col_id[k] !== exp_id[k] || col_prod[k] !== exp_p[k] || col_last[k] !== exp_l[k]) begin
        failures++;
        $display("FAIL burst_seq[%0d]: id=%0d prod=%0d last=%b want %0d/%0d/%b", k, col_id[k], col_prod[k], col_last[k], exp_id[k], exp_p[k], exp_l[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int k = 0; k < 8; k++) load(0, AW'(k + 1), 4'd15, (k == 7));
    drive_srcs();
    #1;
    for (int c = 0; c < 25; c++) begin
      if (c >= 4 && c <= 8) begin
        checks++;
        if (out_valid !== 1'b1 || out_prod !== 75'd45 || out_id !== 2'd0 || out_last !== 1'b0 || req_ready !== 4'b0000) begin
          failures++;
          $display("FAIL stall_hold[c%0d]: valid=%b prod=%0d id=%0d last=%b ready=%b want 1/45/0/0/0000",
                   c, out_valid, out_prod, out_id, out_last, req_ready);
        end
      end
      step(!(c >= 3 && c <= 7));
    end
    checks++;
    if (col_n !== 8) begin failures++; $display("FAIL stall_count: got %0d results want 8", col_n); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (col_prod[k] !== PW'(15 * (k + 1)) || col_last[k] !== (k == 7)) begin
        failures++;
        $display("FAIL stall_seq[%0d]: prod=%0d last=%b want %0d/%b", k, col_prod[k], col_last[k], 15 * (k + 1), (k == 7));
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int k = 0; k < 3; k++) load(0, 71'd1, 4'd1, (k == 2));
    drive_srcs();
    #1;
    step(1'b1);
    step(1'b0);
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL rst_precond: valid=%b busy=%b want 1/1", out_valid, busy);
    end
    #2;
    ap_rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_prod, out_id, out_last, req_ready, busy} !== '0) begin
      failures++;
      $display("FAIL rst_async: valid=%b prod=%h id=%0d last=%b ready=%b busy=%b want all 0",
               out_valid, out_prod, out_id, out_last, req_ready, busy);
    end
    @(negedge ap_clk);
    clear_srcs();
    load(3, 71'd3, 4'd1, 1'b1);
    load(0, 71'd4, 4'd1, 1'b1);
    drive_srcs();
    out_ready = 1'b1;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    #1;
    for (int c = 0; c < 10; c++) step(1'b1);
    checks++;
    if (col_n !== 2 || col_id[0] !== 2'd0 || col_id[1] !== 2'd3 || col_prod[0] !== 75'd4 || col_prod[1] !== 75'd3) begin
      failures++;
      $display("FAIL rst_restart: n=%0d id0=%0d id1=%0d p0=%0d p1=%0d want 2/0/3/4/3",
               col_n, col_id[0], col_id[1], col_prod[0], col_prod[1]);
    end
  endtask

  initial begin
    clear_srcs();
    test_reset();
    test_single();
    test_wide();
    test_back_to_back();
    test_burst_hold();
    test_backpressure();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
